// File: rtl/pb_io_pkg.sv
// Shared constants for the processor I/O controller: port map, key codes and
// interrupt FSM state encoding.
package pb_io_pkg;

  localparam logic [7:0] PortData   = 8'h00;
  localparam logic [7:0] PortStatus = 8'hFE;
  localparam logic [7:0] PortEoi    = 8'hFF;

  localparam logic [7:0] KeySumar     = 8'h57;
  localparam logic [7:0] KeyRestar    = 8'h53;
  localparam logic [7:0] KeyIzquierda = 8'h65;
  localparam logic [7:0] KeyDerecha   = 8'h68;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } irq_state_e;

endpackage

// File: rtl/pb_io_ctrl_if.sv
// Processor-side port bus: address/data strobes, read data and the interrupt
// request/acknowledge pair.
interface pb_io_ctrl_if #(
  parameter int unsigned DATA_W = 8
);

  logic [7:0]        port_id;
  logic [DATA_W-1:0] out_port;
  logic              write_strobe;
  logic              read_strobe;
  logic              interrupt_ack;
  logic [DATA_W-1:0] in_port;
  logic              interrupt;

  modport master (
    output port_id,
    output out_port,
    output write_strobe,
    output read_strobe,
    output interrupt_ack,
    input  in_port,
    input  interrupt
  );

  modport slave (
    input  port_id,
    input  out_port,
    input  write_strobe,
    input  read_strobe,
    input  interrupt_ack,
    output in_port,
    output interrupt
  );

endinterface

// File: rtl/pb_key_decode.sv
// Decodes the port-1 value into registered one-cycle key command pulses.
module pb_key_decode
  import pb_io_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] key,
  output logic              sumar,
  output logic              restar,
  output logic              izquierda,
  output logic              derecha
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sumar     <= 1'b0;
      restar    <= 1'b0;
      izquierda <= 1'b0;
      derecha   <= 1'b0;
    end else begin
      sumar     <= (key == DATA_W'(KeySumar));
      restar    <= (key == DATA_W'(KeyRestar));
      izquierda <= (key == DATA_W'(KeyIzquierda));
      derecha   <= (key == DATA_W'(KeyDerecha));
    end
  end

endmodule

// File: rtl/pb_io_ctrl.sv
// Processor I/O controller: edge-triggered prioritised interrupts with EOI,
// writable output port registers and a key-command decoder on port 1.
module pb_io_ctrl
  import pb_io_pkg::*;
#(
  parameter int unsigned          DATA_W     = 8,
  parameter int unsigned          NUM_OUT    = 4,
  parameter int unsigned          NUM_IRQ    = 4,
  parameter logic [NUM_OUT-1:0]   PULSE_MASK = NUM_OUT'(1)
) (
  input  logic                        clk,
  input  logic                        reset,
  pb_io_ctrl_if.slave                 bus,
  input  logic [NUM_IRQ-1:0]          irq_src,
  input  logic [NUM_IRQ*DATA_W-1:0]   irq_data,
  output logic [NUM_OUT*DATA_W-1:0]   port_q,
  output logic                        sumar,
  output logic                        restar,
  output logic                        izquierda,
  output logic                        derecha
);

  localparam int unsigned CurW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  function automatic logic [CurW-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    lowest_set = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CurW'(i);
    end
  endfunction

  irq_state_e          state_q;
  logic [CurW-1:0]     cur_q;
  logic                interrupt_q;
  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  irq_armed_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  irq_rise;
  logic [NUM_IRQ-1:0]  pend_clr;
  logic                ack_fire;
  logic                eoi;
  logic [DATA_W-1:0]   pend_ext;
  logic [DATA_W-1:0]   in_port_d;
  logic [NUM_OUT*DATA_W-1:0] port_d;
  logic                unused_read_strobe;

  // Status reads are side-effect free, so the read qualifier is not needed.
  assign unused_read_strobe = bus.read_strobe;

  // A source counts only once it has been seen low since reset.
  assign irq_rise = irq_src & ~irq_q & irq_armed_q;
  assign ack_fire = (state_q == StReq) && bus.interrupt_ack;
  assign eoi      = bus.write_strobe && (bus.port_id == PortEoi);

  always_comb begin
    pend_clr = '0;
    if (ack_fire) pend_clr[cur_q] = 1'b1;
  end

  // A new edge on the source being acknowledged wins over its clear.
  assign pending_d = (pending_q & ~pend_clr) | irq_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q       <= '0;
      irq_armed_q <= '0;
      pending_q   <= '0;
    end else begin
      irq_q       <= irq_src;
      irq_armed_q <= irq_armed_q | ~irq_src;
      pending_q   <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      interrupt_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|pending_q) begin
            cur_q       <= lowest_set(pending_q);
            interrupt_q <= 1'b1;
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (bus.interrupt_ack) begin
            interrupt_q <= 1'b0;
            state_q     <= StService;
          end
        end
        StService: begin
          if (eoi) state_q <= StIdle;
        end
        default: begin
          interrupt_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.interrupt = interrupt_q;

  always_comb begin
    pend_ext                = '0;
    pend_ext[NUM_IRQ-1:0]   = pending_q;
    in_port_d               = '0;
    if ((bus.port_id == PortData) && (state_q != StIdle)) begin
      in_port_d = irq_data[int'(cur_q)*DATA_W +: DATA_W];
    end else if (bus.port_id == PortStatus) begin
      in_port_d = pend_ext;
    end
  end

  assign bus.in_port = in_port_d;

  // Pulse-mode ports drop back to zero on any cycle they are not rewritten.
  always_comb begin
    port_d = port_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (PULSE_MASK[k]) port_d[k*DATA_W +: DATA_W] = '0;
      if (bus.write_strobe && (bus.port_id == 8'(k + 1))) begin
        port_d[k*DATA_W +: DATA_W] = bus.out_port;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_q <= '0;
    end else begin
      port_q <= port_d;
    end
  end

  pb_key_decode #(
    .DATA_W (DATA_W)
  ) u_key_decode (
    .clk       (clk),
    .reset     (reset),
    .key       (port_q[DATA_W-1:0]),
    .sumar     (sumar),
    .restar    (restar),
    .izquierda (izquierda),
    .derecha   (derecha)
  );

endmodule

// File: tb/tb_pb_io_ctrl.sv
// Self-checking bench for pb_io_ctrl: port-write table, directed interrupt
// sequences and a randomized run against a behavioural model.
module tb_pb_io_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  irq_src;
  logic [31:0] irq_data;
  logic [31:0] port_q;
  logic        sumar, restar, izquierda, derecha;

  int n_checks;
  int n_errors;

  pb_io_ctrl_if #(.DATA_W(8)) bus ();

  pb_io_ctrl #(
    .DATA_W     (8),
    .NUM_OUT    (4),
    .NUM_IRQ    (4),
    .PULSE_MASK (4'b0001)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .irq_src   (irq_src),
    .irq_data  (irq_data),
    .port_q    (port_q),
    .sumar     (sumar),
    .restar    (restar),
    .izquierda (izquierda),
    .derecha   (derecha)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase 0 = idle, 1 = requesting, 2 = in service.
  int         m_phase;
  int         m_cur;
  logic [3:0] m_pend;
  logic [3:0] m_last;
  logic [3:0] m_seen_low;
  logic       m_irq;
  logic [7:0] m_port [4];
  logic [3:0] m_key;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase    = 0;
    m_cur      = 0;
    m_pend     = '0;
    m_last     = '0;
    m_seen_low = '0;
    m_irq      = 1'b0;
    m_key      = '0;
    for (int i = 0; i < 4; i++) m_port[i] = '0;
  endtask

  task automatic model_step();
    logic [3:0] rises;
    logic [3:0] cleared;
    logic [7:0] p1;
    rises   = '0;
    cleared = '0;
    for (int i = 0; i < 4; i++) begin
      if (irq_src[i] && !m_last[i] && m_seen_low[i]) rises[i] = 1'b1;
    end
    if (m_phase == 0) begin
      if (m_pend != 0) begin
        for (int i = 0; i < 4; i++) begin
          if (m_pend[i]) begin
            m_cur = i;
            break;
          end
        end
        m_irq   = 1'b1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (bus.interrupt_ack) begin
        cleared[m_cur] = 1'b1;
        m_irq   = 1'b0;
        m_phase = 2;
      end
    end else begin
      if (bus.write_strobe && bus.port_id == 8'hFF) m_phase = 0;
    end
    m_pend = (m_pend & ~cleared) | rises;
    p1 = m_port[0];
    m_key = {p1 == 8'h57, p1 == 8'h53, p1 == 8'h65, p1 == 8'h68};
    m_port[0] = 8'h00;
    if (bus.write_strobe && bus.port_id >= 8'd1 && bus.port_id <= 8'd4) begin
      m_port[bus.port_id - 8'd1] = bus.out_port;
    end
    for (int i = 0; i < 4; i++) if (!irq_src[i]) m_seen_low[i] = 1'b1;
    m_last = irq_src;
  endtask

  function automatic logic [7:0] model_in_port();
    if (bus.port_id == 8'h00 && m_phase != 0) return irq_data[m_cur*8 +: 8];
    if (bus.port_id == 8'hFE) return {4'b0, m_pend};
    return 8'h00;
  endfunction

  task automatic check_all();
    chk("interrupt", {31'b0, bus.interrupt}, {31'b0, m_irq});
    chk("port_q", port_q, {m_port[3], m_port[2], m_port[1], m_port[0]});
    chk("keys", {28'b0, sumar, restar, izquierda, derecha}, {28'b0, m_key});
    chk("in_port", {24'b0, bus.in_port}, {24'b0, model_in_port()});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
    check_all();
  endtask

  task automatic write(input logic [7:0] pid, input logic [7:0] data);
    bus.write_strobe = 1'b1;
    bus.port_id      = pid;
    bus.out_port     = data;
    tick();
    bus.write_strobe = 1'b0;
  endtask

  task automatic ack();
    bus.interrupt_ack = 1'b1;
    tick();
    bus.interrupt_ack = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [7:0] pid, input logic [7:0] exp);
    bus.port_id     = pid;
    bus.read_strobe = 1'b1;
    #1;
    chk(name, {24'b0, bus.in_port}, {24'b0, exp});
    bus.read_strobe = 1'b0;
  endtask

  task automatic assert_reset_now();
    rst_n = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  pid;
    logic [7:0]  data;
    logic [31:0] exp_port;
    logic [3:0]  exp_key;
  } vec_t;

  vec_t vecs [15];
  logic [7:0] pids [8];

  initial begin
    n_checks = 0;
    n_errors = 0;
    vecs[0]  = '{8'h03, 8'hA5, 32'h00A50000, 4'b0000};
    vecs[1]  = '{8'h09, 8'h11, 32'h00A50000, 4'b0000};
    vecs[2]  = '{8'h02, 8'h3C, 32'h00A53C00, 4'b0000};
    vecs[3]  = '{8'hFE, 8'h77, 32'h00A53C00, 4'b0000};
    vecs[4]  = '{8'h00, 8'h77, 32'h00A53C00, 4'b0000};
    vecs[5]  = '{8'h04, 8'hC3, 32'hC3A53C00, 4'b0000};
    vecs[6]  = '{8'h01, 8'h41, 32'hC3A53C41, 4'b0000};
    vecs[7]  = '{8'h02, 8'h99, 32'hC3A59900, 4'b0000};
    vecs[8]  = '{8'h01, 8'h57, 32'hC3A59957, 4'b0000};
    vecs[9]  = '{8'h03, 8'h00, 32'hC3009900, 4'b1000};
    vecs[10] = '{8'h01, 8'h68, 32'hC3009968, 4'b0000};
    vecs[11] = '{8'hFF, 8'h00, 32'hC3009900, 4'b0001};
    vecs[12] = '{8'h01, 8'h53, 32'hC3009953, 4'b0000};
    vecs[13] = '{8'h01, 8'h65, 32'hC3009965, 4'b0100};
    vecs[14] = '{8'h05, 8'h00, 32'hC3009900, 4'b0010};
    pids = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFE, 8'hFF, 8'h09};

    rst_n             = 1'b0;
    irq_src           = '0;
    irq_data          = {8'h33, 8'h22, 8'h11, 8'h02};
    bus.port_id       = '0;
    bus.out_port      = '0;
    bus.write_strobe  = 1'b0;
    bus.read_strobe   = 1'b0;
    bus.interrupt_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_all();
    chk("rst_port_q", port_q, 32'h0);
    read_chk("rst_status", 8'hFE, 8'h00);
    rst_n = 1'b1;

    // Port write table.
    for (int i = 0; i < 15; i++) begin
      write(vecs[i].pid, vecs[i].data);
      chk("tbl_port_q", port_q, vecs[i].exp_port);
      chk("tbl_keys", {28'b0, sumar, restar, izquierda, derecha}, {28'b0, vecs[i].exp_key});
    end
    tick();

    // Key pulse timing: sumar one cycle, two edges after the strobe.
    write(8'h01, 8'h57);
    chk("key_p1_loaded", {24'b0, port_q[7:0]}, 32'h57);
    chk("key_sumar_early", {31'b0, sumar}, 32'h0);
    tick();
    chk("key_p1_cleared", {24'b0, port_q[7:0]}, 32'h00);
    chk("key_sumar_pulse", {31'b0, sumar}, 32'h1);
    tick();
    chk("key_sumar_gone", {31'b0, sumar}, 32'h0);
    write(8'h01, 8'h41);
    repeat (2) begin
      tick();
      chk("key_none", {28'b0, sumar, restar, izquierda, derecha}, 32'h0);
    end

    // Reset during REQ; a source already high must not retrigger.
    irq_src = 4'b0001;
    tick();
    tick();
    chk("mid_req_irq", {31'b0, bus.interrupt}, 32'h1);
    assert_reset_now();
    chk("rst_mid_irq", {31'b0, bus.interrupt}, 32'h0);
    chk("rst_mid_port_q", port_q, 32'h0);
    read_chk("rst_mid_status", 8'hFE, 8'h00);
    release_reset();
    repeat (3) tick();
    chk("no_retrigger_irq", {31'b0, bus.interrupt}, 32'h0);
    read_chk("no_retrigger_pend", 8'hFE, 8'h00);

    // Single interrupt on source 0.
    irq_src = 4'b0000;
    tick();
    irq_src = 4'b0001;
    tick();
    chk("single_irq_wait", {31'b0, bus.interrupt}, 32'h0);
    read_chk("single_pend", 8'hFE, 8'h01);
    tick();
    chk("single_irq", {31'b0, bus.interrupt}, 32'h1);
    read_chk("single_data", 8'h00, 8'h02);
    ack();
    chk("single_ack_irq", {31'b0, bus.interrupt}, 32'h0);
    read_chk("single_ack_pend", 8'hFE, 8'h00);
    read_chk("single_svc_data", 8'h00, 8'h02);
    write(8'hFF, 8'h00);

    // Simultaneous edges on sources 3 and 1: 1 first, then 3 after EOI.
    irq_src = 4'b1011;
    tick();
    tick();
    chk("prio_irq1", {31'b0, bus.interrupt}, 32'h1);
    read_chk("prio_data1", 8'h00, 8'h11);
    ack();
    write(8'hFF, 8'h00);
    chk("prio_eoi_irq", {31'b0, bus.interrupt}, 32'h0);
    tick();
    chk("prio_irq3", {31'b0, bus.interrupt}, 32'h1);
    read_chk("prio_data3", 8'h00, 8'h33);
    ack();
    write(8'hFF, 8'h00);

    // Source 0 edge while source 2 is in service is held until EOI.
    irq_src = 4'b0100;
    tick();
    tick();
    read_chk("svc_data2", 8'h00, 8'h22);
    ack();
    irq_src = 4'b0101;
    repeat (3) begin
      tick();
      chk("svc_blocked", {31'b0, bus.interrupt}, 32'h0);
    end
    read_chk("svc_pend", 8'hFE, 8'h01);
    write(8'hFF, 8'h00);
    chk("svc_eoi_irq", {31'b0, bus.interrupt}, 32'h0);
    tick();
    chk("svc_irq0", {31'b0, bus.interrupt}, 32'h1);
    read_chk("svc_data0", 8'h00, 8'h02);
    ack();
    write(8'hFF, 8'h00);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) irq_data = $urandom;
      if ($urandom_range(7) == 0) irq_src[$urandom_range(3)] ^= 1'b1;
      bus.port_id      = pids[$urandom_range(7)];
      bus.write_strobe = ($urandom_range(2) == 0);
      bus.read_strobe  = ($urandom_range(3) == 0);
      case ($urandom_range(5))
        0:       bus.out_port = 8'h57;
        1:       bus.out_port = 8'h53;
        2:       bus.out_port = 8'h65;
        3:       bus.out_port = 8'h68;
        default: bus.out_port = 8'($urandom);
      endcase
      bus.interrupt_ack = m_irq && ($urandom_range(2) == 0);
      if (c % 700 == 350) begin
        assert_reset_now();
        check_all();
        release_reset();
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pb_io_ctrl.md
PB_IO_CTRL -- requirements
Module: pb_io_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning processor port data width.
REQ-002 The block SHALL have parameter NUM_OUT, default 4, meaning count of output port registers, port_id 1..NUM_OUT.
REQ-003 The block SHALL have parameter NUM_IRQ, default 4, meaning interrupt sources, index 0 highest priority.
REQ-004 The block SHALL have parameter PULSE_MASK, default 4'b0001, meaning bit i set makes output port i+1 self-clearing.
REQ-005 The block SHALL have the following ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low.
- port_id  in  8  processor port address.
- out_port  in  DATA_W  processor write data.
- write_strobe  in  1  write qualifier.
- read_strobe  in  1  read qualifier.
- interrupt_ack  in  1  processor acknowledge.
- irq_src  in  NUM_IRQ  source request levels.
- irq_data  in  NUM_IRQ*DATA_W  per-source data, source i at bits [i*DATA_W +: DATA_W].
- in_port  out  DATA_W  processor read data, combinational.
- interrupt  out  1  processor interrupt request, registered.
- port_q  out  NUM_OUT*DATA_W  output port registers.
- sumar, restar, izquierda, derecha  out  1 each  registered key-command pulses.

Function
REQ-006 Each irq_src bit SHALL be registered, and a rising edge SHALL set pending[i] on the following cycle.
REQ-007 The interrupt FSM SHALL have states IDLE, REQ and SERVICE.
REQ-008 In IDLE, if any pending bit is set, the FSM SHALL latch the lowest set index into cur, enter REQ, and assert interrupt on the next cycle.
REQ-009 In REQ, interrupt SHALL stay high until interrupt_ack; on interrupt_ack the FSM SHALL clear pending[cur], deassert interrupt, and enter SERVICE.
REQ-010 In SERVICE, a write_strobe with port_id 0xFF (EOI) SHALL return the FSM to IDLE; a new request SHALL be raised no earlier than the cycle after EOI.
REQ-011 When a rising edge on source cur and its pending clear coincide, pending SHALL remain set.
REQ-012 Edges arriving during REQ or SERVICE SHALL only set pending bits; priority is evaluated only in IDLE.
REQ-013 in_port SHALL equal irq_data[cur] when port_id is 0x00 and state is REQ or SERVICE.
REQ-014 in_port SHALL equal the pending vector zero-extended when port_id is 0xFE.
REQ-015 in_port SHALL be 0 in all other cases.
REQ-016 A read_strobe with port_id 0xFE SHALL clear nothing; pending bits are cleared only through acknowledge.
REQ-017 A write_strobe with port_id k in 1..NUM_OUT SHALL load out_port into port k on the next edge; other ports SHALL hold.
REQ-018 A port whose PULSE_MASK bit is set SHALL return to 0 one cycle after being written, unless it is written again in that cycle.
REQ-019 Port 1 SHALL feed the key decoder: 0x57 gives sumar, 0x53 gives restar, 0x65 gives izquierda, 0x68 gives derecha.
REQ-020 Each key command SHALL be a one-cycle pulse, registered, appearing 2 cycles after the write_strobe.
REQ-021 Any other port 1 value SHALL produce no key pulse.
REQ-022 A write_strobe with port_id 0x00, port_id 0xFE, or port_id above NUM_OUT other than 0xFF SHALL be ignored.

Reset
REQ-023 On reset low, asynchronously: FSM SHALL be IDLE; interrupt, pending, cur, the irq_src registers, all port_q, and all key pulses SHALL be 0.
REQ-024 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the service with no pending bit retained.
REQ-025 After reset release, irq_src bits already high SHALL be seen as edges only after they go low and then high again.

Structure
REQ-026 Port addresses (0x00 data, 0xFE status, 0xFF EOI), the key codes, and the FSM state encoding SHALL live in a shared package pb_io_pkg.
REQ-027 Key decoding and its output registers SHALL be the sub-module pb_key_decode, with a DATA_W-bit input and 4 registered pulse outputs.

Verification
REQ-028 Reset mid-operation: irq_src=0001, drop reset during REQ -> interrupt=0, pending=0, port_q=0 immediately.
REQ-029 Single interrupt: irq_src=0001 with irq_data[0]=0x02 -> interrupt high 2 cycles after the edge; read port 0x00 returns 0x02; after ack, interrupt=0 and pending=0.
REQ-030 Priority: edges on sources 3 and 1 in the same cycle -> source 1 is served first; after EOI, source 3 is requested with in_port=irq_data[3].
REQ-031 Service protection: an edge on source 0 during SERVICE of source 2 -> no interrupt until EOI is written, then interrupt for source 0.
REQ-032 Key pulses: write 0x57 to port 1 -> sumar high for exactly 1 cycle 2 cycles later; port 1 reads 0 after 1 cycle; write 0x41 -> no pulses.
REQ-033 Ports and status: write 0xA5 to port 3 -> port 3 holds 0xA5; writes to port 0x09 are ignored; a status read returns the pending bits.
